keypad_emulator: RTL

- Synthesizable 4x4 matrix-keypad responder; the opposite end of the column-scan/row-sense interface driven by the Teclado scanner.
- Watches the scanner's column drive and answers on the row lines as if a chosen key were physically pressed, with contact bounce, hold time and release gap.
- Key index and press request come from board switches (prueba / pruebaOPR), so the keypad, register bank, VGA and display path can be exercised on the board without the physical keypad.

---
 rtl/keypad_emulator_pkg.sv | 27 ++
 rtl/keypad_emulator_bounce_gen.sv | 56 +++++
 rtl/keypad_emulator.sv | 132 +++++++++++++
 3 files changed

// File: rtl/keypad_emulator_pkg.sv
// Shared definitions for the keypad emulator: FSM states, key split helpers
// and the column/row active levels agreed with the Teclado scanner.
package keypad_emulator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BOUNCE_IN,
        ST_HELD,
        ST_BOUNCE_OUT,
        ST_GAP
    } state_t;

    localparam logic COL_ACTIVE = 1'b1;

    function automatic logic [1:0] key_row(input logic [3:0] k);
        return k[3:2];
    endfunction

    function automatic logic [1:0] key_col(input logic [3:0] k);
        return k[1:0];
    endfunction

    function automatic logic [3:0] row_onehot(input logic [1:0] r);
        return 4'b0001 << r;
    endfunction

endpackage

// File: rtl/keypad_emulator_bounce_gen.sv
// Contact bounce generator: start_make/start_break load the contact level, then
// 2*N_BOUNCE toggles every BOUNCE_CYC cycles; phase_done flags the final toggle.
module keypad_emulator_bounce_gen #(
    parameter int BOUNCE_CYC = 50000,
    parameter int N_BOUNCE   = 3,
    parameter int CNT_W      = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic start_make,
    input  logic start_break,
    output logic contact,
    output logic phase_done
);

    localparam int TW = $clog2(2 * N_BOUNCE + 2);
    localparam logic [CNT_W-1:0] BC_LAST = CNT_W'(BOUNCE_CYC - 1);
    localparam logic [TW-1:0]    TG_LAST = TW'(2 * N_BOUNCE - 1);

    logic             active_q;
    logic [CNT_W-1:0] cnt_q;
    logic [TW-1:0]    tog_q;
    logic             contact_q;
    logic             toggle;

    assign toggle     = active_q && (cnt_q == BC_LAST);
    assign phase_done = toggle && (tog_q == TG_LAST);
    assign contact    = contact_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q  <= 1'b0;
            cnt_q     <= '0;
            tog_q     <= '0;
            contact_q <= 1'b0;
        end else if (start_make || start_break) begin
            // With no bounce the loaded level simply stays put for the phase.
            contact_q <= start_make;
            active_q  <= (N_BOUNCE != 0);
            cnt_q     <= '0;
            tog_q     <= '0;
        end else if (active_q) begin
            if (toggle) begin
                cnt_q     <= '0;
                contact_q <= ~contact_q;
                tog_q     <= tog_q + TW'(1);
                if (phase_done) begin
                    active_q <= 1'b0;
                end
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/keypad_emulator.sv
// 4x4 keypad responder: answers the scanner's column drive on fila as if key_idx were pressed.
// Latency 1 clk from col/contact to fila; presses arriving while busy only set drop.
module keypad_emulator
    import keypad_emulator_pkg::*;
#(
    parameter int BOUNCE_CYC = 50000,
    parameter int N_BOUNCE   = 3,
    parameter int HOLD_CYC   = 5000000,
    parameter int GAP_CYC    = 2500000,
    parameter int CNT_W      = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_idx,
    input  logic       press,
    input  logic [3:0] col,
    output logic [3:0] fila,
    output logic       busy,
    output logic       done,
    output logic       drop
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);

    state_t           state_q;
    logic             press_q;
    logic [1:0]       row_l_q;
    logic [1:0]       col_l_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             busy_q;
    logic             done_q;
    logic             drop_q;
    logic [3:0]       fila_q;

    logic start;
    logic start_make;
    logic start_break;
    logic contact;
    logic phase_done;

    assign start       = press & ~press_q;
    assign start_make  = (state_q == ST_IDLE) && start;
    assign start_break = (state_q == ST_HELD) && (cnt_q == HOLD_LAST);
    assign cnt_inc     = cnt_q + CNT_W'(1);

    keypad_emulator_bounce_gen #(
        .BOUNCE_CYC (BOUNCE_CYC),
        .N_BOUNCE   (N_BOUNCE),
        .CNT_W      (CNT_W)
    ) u_bounce (
        .clk         (clk),
        .rst         (rst),
        .start_make  (start_make),
        .start_break (start_break),
        .contact     (contact),
        .phase_done  (phase_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            press_q <= 1'b0;
            row_l_q <= '0;
            col_l_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
            fila_q  <= '0;
        end else begin
            press_q <= press;
            done_q  <= 1'b0;
            fila_q  <= (contact && (col[col_l_q] == COL_ACTIVE)) ? row_onehot(row_l_q) : 4'b0000;
            // busy_q is still high in the done cycle, so a start there is dropped too.
            if (start && busy_q) begin
                drop_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        row_l_q <= key_row(key_idx);
                        col_l_q <= key_col(key_idx);
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= (N_BOUNCE == 0) ? ST_HELD : ST_BOUNCE_IN;
                    end
                end
                ST_BOUNCE_IN: begin
                    if (phase_done) begin
                        cnt_q   <= '0;
                        state_q <= ST_HELD;
                    end
                end
                ST_HELD: begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_q   <= '0;
                        state_q <= (N_BOUNCE == 0) ? ST_GAP : ST_BOUNCE_OUT;
                        done_q  <= (N_BOUNCE == 0) && (GAP_CYC == 1);
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                ST_BOUNCE_OUT: begin
                    if (phase_done) begin
                        cnt_q   <= '0;
                        state_q <= ST_GAP;
                        done_q  <= (GAP_CYC == 1);
                    end
                end
                ST_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q  <= cnt_inc;
                        done_q <= (cnt_inc == GAP_LAST);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign fila = fila_q;
    assign busy = busy_q;
    assign done = done_q;
    assign drop = drop_q;

endmodule
